// File: rtl/load_store_unit_pkg.sv
// Shared op codes, FSM state encoding and request classification helpers
// for the load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:          bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH:  bad = lo[0];
      default:               bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: extended load extraction and
// store-lane merge into an existing little-endian memory word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = '0;
    case (byte_sel)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = byte_sel[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = '0;
    case (op)
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0000, half_v};
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h000000, byte_v};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (op)
      OP_SW: store_word = wdata;
      OP_SH: begin
        if (byte_sel[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      OP_SB: store_word[{byte_sel, 3'b000} +: 8] = wdata[7:0];
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller in front of a word-addressed data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  state_t              state, next_state;
  logic [2:0]          op_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   merge_q;
  logic                err_q;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   store_word;

  lsu_lane_align u_align (
    .op         (op_q),
    .byte_sel   (addr_q[1:0]),
    .word       (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid)
          next_state = is_misaligned(req_op, req_addr[1:0]) ? RESP : EXEC;
      end
      EXEC:    next_state = (is_store(op_q) && (op_q != OP_SW)) ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      err_q      <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= is_misaligned(req_op, req_addr[1:0]);
            resp_rdata <= '0;
          end
        end
        EXEC: begin
          if (!is_store(op_q)) resp_rdata <= load_data;
          merge_q <= store_word;
        end
        default: ;
      endcase
    end
  end

  // Write enable is a pure state decode so an async reset kills it at once.
  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    resp_err       = (state == RESP) && err_q;
    mem_we         = (state == WRITE) || ((state == EXEC) && (op_q == OP_SW));
    mem_wdata      = (state == WRITE) ? merge_q : wdata_q;
    mem_read_addr  = addr_q[ADDR_W+1:2];
    mem_write_addr = addr_q[ADDR_W+1:2];
  end

endmodule
